// File: rtl/fpu_op_scheduler.sv
// Two-port round-robin scheduler in front of one shared combinational FP32 ALU.
// Define FPU_SCHED_STATS_EN to add saturating handshake/exception/zeroDiv counters.
module fpu_op_scheduler #(
    parameter int SETTLE = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [63:0]       req_A,
    input  logic [63:0]       req_B,
    input  logic [3:0]        req_sel,
    output logic [1:0]        rsp_valid,
    input  logic [1:0]        rsp_ready,
    output logic [31:0]       rsp_out,
    output logic              rsp_exception,
    output logic              rsp_zeroDiv,
    output logic [31:0]       alu_A,
    output logic [31:0]       alu_B,
    output logic [1:0]        alu_select,
    output logic              alu_control,
    input  logic [31:0]       alu_out,
    input  logic              alu_exception,
    input  logic              alu_zeroDiv,
`ifdef FPU_SCHED_STATS_EN
    output logic [CNT_W-1:0]  stat_ops0,
    output logic [CNT_W-1:0]  stat_ops1,
    output logic [CNT_W-1:0]  stat_exc,
    output logic [CNT_W-1:0]  stat_zdiv,
    input  logic              stat_clr,
`endif
    output logic              busy
);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

    state_t      state_q, state_d;
    logic        ptr_q, ptr_d;
    logic        owner_q, owner_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] alu_a_q, alu_a_d;
    logic [31:0] alu_b_q, alu_b_d;
    logic [1:0]  alu_sel_q, alu_sel_d;
    logic [1:0]  rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_out_q, rsp_out_d;
    logic        rsp_exc_q, rsp_exc_d;
    logic        rsp_zdiv_q, rsp_zdiv_d;

    logic gnt_any;
    logic gnt_port;
    logic capture;
    logic handshake;

    // Only one valid port wins outright; with both valid the pointer decides.
    always_comb begin
        gnt_any   = (state_q == ST_IDLE) && (req_valid != 2'b00);
        gnt_port  = (req_valid == 2'b11) ? ptr_q : req_valid[1];
        capture   = (state_q == ST_WAIT) && (cnt_q == 4'd0);
        handshake = (state_q == ST_RESP) && rsp_ready[owner_q];
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (gnt_any)   state_d = ST_WAIT;
            ST_WAIT: if (capture)   state_d = ST_RESP;
            ST_RESP: if (handshake) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready   = 2'b00;
        if (gnt_any) req_ready = gnt_port ? 2'b10 : 2'b01;
        alu_control = (state_q == ST_WAIT);
        busy        = (state_q != ST_IDLE);
    end

    always_comb begin
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        rsp_valid_d = rsp_valid_q;
        rsp_out_d   = rsp_out_q;
        rsp_exc_d   = rsp_exc_q;
        rsp_zdiv_d  = rsp_zdiv_q;
        if (gnt_any) begin
            alu_a_d   = gnt_port ? req_A[63:32]  : req_A[31:0];
            alu_b_d   = gnt_port ? req_B[63:32]  : req_B[31:0];
            alu_sel_d = gnt_port ? req_sel[3:2]  : req_sel[1:0];
            owner_d   = gnt_port;
            ptr_d     = ~ptr_q;
            cnt_d     = SETTLE_M1;
        end
        if (state_q == ST_WAIT && !capture) cnt_d = cnt_q - 4'd1;
        if (capture) begin
            rsp_out_d   = alu_out;
            rsp_exc_d   = alu_exception;
            rsp_zdiv_d  = alu_zeroDiv;
            rsp_valid_d = owner_q ? 2'b10 : 2'b01;
        end
        if (handshake) rsp_valid_d = 2'b00;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q       <= 1'b0;
            owner_q     <= 1'b0;
            cnt_q       <= 4'd0;
            alu_a_q     <= 32'd0;
            alu_b_q     <= 32'd0;
            alu_sel_q   <= 2'd0;
            rsp_valid_q <= 2'b00;
            rsp_out_q   <= 32'd0;
            rsp_exc_q   <= 1'b0;
            rsp_zdiv_q  <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_out_q   <= rsp_out_d;
            rsp_exc_q   <= rsp_exc_d;
            rsp_zdiv_q  <= rsp_zdiv_d;
        end
    end

    assign alu_A         = alu_a_q;
    assign alu_B         = alu_b_q;
    assign alu_select    = alu_sel_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_out       = rsp_out_q;
    assign rsp_exception = rsp_exc_q;
    assign rsp_zeroDiv   = rsp_zdiv_q;

`ifdef FPU_SCHED_STATS_EN
    logic [CNT_W-1:0] ops0_q, ops0_d;
    logic [CNT_W-1:0] ops1_q, ops1_d;
    logic [CNT_W-1:0] exc_q, exc_d;
    logic [CNT_W-1:0] zdiv_q, zdiv_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        sat_inc = (inc && (v != {CNT_W{1'b1}})) ? v + 1'b1 : v;
    endfunction

    // Clear wins over a same-cycle increment.
    always_comb begin
        ops0_d = sat_inc(ops0_q, handshake && !owner_q);
        ops1_d = sat_inc(ops1_q, handshake &&  owner_q);
        exc_d  = sat_inc(exc_q,  capture && alu_exception);
        zdiv_d = sat_inc(zdiv_q, capture && alu_zeroDiv);
        if (stat_clr) begin
            ops0_d = '0;
            ops1_d = '0;
            exc_d  = '0;
            zdiv_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ops0_q <= '0;
            ops1_q <= '0;
            exc_q  <= '0;
            zdiv_q <= '0;
        end else begin
            ops0_q <= ops0_d;
            ops1_q <= ops1_d;
            exc_q  <= exc_d;
            zdiv_q <= zdiv_d;
        end
    end

    assign stat_ops0 = ops0_q;
    assign stat_ops1 = ops1_q;
    assign stat_exc  = exc_q;
    assign stat_zdiv = zdiv_q;
`endif

endmodule

// File: tb/tb_fpu_op_scheduler.sv
// Directed bench for fpu_op_scheduler: mock FP32 ALU, scoreboard of expected responses.
// Build with +define+FPU_SCHED_STATS_EN to also exercise the statistics counters.
module tb_fpu_op_scheduler;

    localparam int SETTLE = 2;
    localparam int CNT_W  = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_A;
    logic [63:0] req_B;
    logic [3:0]  req_sel;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_out;
    logic        rsp_exception;
    logic        rsp_zeroDiv;
    logic [31:0] alu_A;
    logic [31:0] alu_B;
    logic [1:0]  alu_select;
    logic        alu_control;
    logic [31:0] alu_out;
    logic        alu_exception;
    logic        alu_zeroDiv;
    logic        busy;
`ifdef FPU_SCHED_STATS_EN
    logic [CNT_W-1:0] stat_ops0, stat_ops1, stat_exc, stat_zdiv;
    logic             stat_clr;
`endif

    always #5 clk = ~clk;

    fpu_op_scheduler #(.SETTLE(SETTLE), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_A(req_A), .req_B(req_B), .req_sel(req_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_out(rsp_out), .rsp_exception(rsp_exception), .rsp_zeroDiv(rsp_zeroDiv),
        .alu_A(alu_A), .alu_B(alu_B), .alu_select(alu_select), .alu_control(alu_control),
        .alu_out(alu_out), .alu_exception(alu_exception), .alu_zeroDiv(alu_zeroDiv),
`ifdef FPU_SCHED_STATS_EN
        .stat_ops0(stat_ops0), .stat_ops1(stat_ops1), .stat_exc(stat_exc),
        .stat_zdiv(stat_zdiv), .stat_clr(stat_clr),
`endif
        .busy(busy)
    );

    // Mock ALU: a few real FP32 results, a scrambling function otherwise.
    function automatic logic [33:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [1:0] sel);
        if (sel == 2'b00 && a == 32'h3F800000 && b == 32'h40000000) return {2'b00, 32'h40400000};
        if (sel == 2'b11 && a == 32'h3F800000 && b == 32'h00000000) return {2'b01, 32'h7F800000};
        if (sel == 2'b00 && a == 32'h7F800000 && b == 32'hFF800000) return {2'b10, 32'h7FC00000};
        return {1'b0, (sel == 2'b11) && (b[30:0] == 31'd0), a + {b[15:0], b[31:16]} + 32'(sel)};
    endfunction

    // The mock only produces a valid result once its inputs have been held SETTLE-1 edges.
    int          settle_cnt;
    logic [33:0] alu_res;
    always @(posedge clk or negedge reset) begin
        if (!reset)           settle_cnt <= 0;
        else if (alu_control) settle_cnt <= settle_cnt + 1;
        else                  settle_cnt <= 0;
    end
    always_comb begin
        alu_res = alu_model(alu_A, alu_B, alu_select);
        if (settle_cnt < SETTLE - 1) alu_res = {2'b11, 32'hDEADBEEF};
    end
    assign {alu_exception, alu_zeroDiv, alu_out} = alu_res;

    typedef struct {
        logic        port;
        logic [31:0] data;
        logic        exc;
        logic        zdiv;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"},  req_ready,     64'd0);
        check({tag, "_rsp_valid"},  rsp_valid,     64'd0);
        check({tag, "_rsp_out"},    rsp_out,       64'd0);
        check({tag, "_rsp_exc"},    rsp_exception, 64'd0);
        check({tag, "_rsp_zdiv"},   rsp_zeroDiv,   64'd0);
        check({tag, "_alu_A"},      alu_A,         64'd0);
        check({tag, "_alu_B"},      alu_B,         64'd0);
        check({tag, "_alu_select"}, alu_select,    64'd0);
        check({tag, "_alu_ctrl"},   alu_control,   64'd0);
        check({tag, "_busy"},       busy,          64'd0);
    endtask

    task automatic drive_port(input int p, input logic [31:0] a, input logic [31:0] b,
                              input logic [1:0] sel);
        if (p == 0) begin
            req_A[31:0] = a; req_B[31:0] = b; req_sel[1:0] = sel;
        end else begin
            req_A[63:32] = a; req_B[63:32] = b; req_sel[3:2] = sel;
        end
    endtask

    // Checks the grant and, when one is expected, queues that port's expected result.
    task automatic expect_grant(input string tag, input logic [1:0] exp);
        exp_t        e;
        logic [33:0] r;
        check(tag, req_ready, exp);
        if (exp != 2'b00) begin
            e.port = exp[1];
            r = exp[1] ? alu_model(req_A[63:32], req_B[63:32], req_sel[3:2])
                       : alu_model(req_A[31:0],  req_B[31:0],  req_sel[1:0]);
            {e.exc, e.zdiv, e.data} = r;
            sb.push_back(e);
        end
    endtask

    // Waits for a response, checks it against the scoreboard, optionally stalls, then handshakes.
    task automatic wait_rsp(input int hold);
        exp_t       e;
        int         n = 0;
        logic [1:0] own;
        while (rsp_valid === 2'b00 && n < 20) begin
            step(); #1; n++;
        end
        check("rsp_arrived", rsp_valid != 2'b00, 64'd1);
        if (sb.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL sb_underflow: observed response 0x%0h, expected none", rsp_out);
            own = rsp_valid;
        end else begin
            e   = sb.pop_front();
            own = e.port ? 2'b10 : 2'b01;
            check("rsp_owner", rsp_valid,     own);
            check("rsp_data",  rsp_out,       e.data);
            check("rsp_exc",   rsp_exception, e.exc);
            check("rsp_zdiv",  rsp_zeroDiv,   e.zdiv);
            for (int i = 0; i < hold; i++) begin
                step();
                rsp_ready = ~own;
                #1;
                check("hold_valid", rsp_valid, own);
                check("hold_data",  rsp_out,   e.data);
                check("hold_grant", req_ready, 64'd0);
                check("hold_busy",  busy,      64'd1);
            end
        end
        rsp_ready = own;
        step();
        rsp_ready = 2'b00;
        #1;
        check("rsp_cleared", rsp_valid, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected $finish");
        $fatal(1);
    end

    initial begin
        reset     = 1'b0;
        req_valid = 2'b00;
        req_A     = '0;
        req_B     = '0;
        req_sel   = '0;
        rsp_ready = 2'b00;
`ifdef FPU_SCHED_STATS_EN
        stat_clr  = 1'b0;
`endif
        repeat (2) step();
        #1;
        check_reset_outputs("por");
        step();
        reset = 1'b1;

        // Contention right after reset: port0, then port1, then port0 again.
        step();
        drive_port(0, 32'h3F800000, 32'h40000000, 2'b00);
        drive_port(1, 32'h40A00000, 32'h40400000, 2'b10);
        req_valid = 2'b11;
        #1;
        expect_grant("cont_first_p0", 2'b01);
        for (int i = 0; i < SETTLE; i++) begin
            step(); #1;
            check("cont_no_grant_busy", req_ready, 64'd0);
        end
        wait_rsp(0);
        expect_grant("cont_then_p1", 2'b10);
        step(); #1;
        wait_rsp(0);
        expect_grant("cont_back_to_p0", 2'b01);
        step();
        req_valid = 2'b00;
        #1;
        wait_rsp(0);

        // Single add with cycle-accurate latency; later req_* changes must not matter.
        step();
        drive_port(0, 32'h3F800000, 32'h40000000, 2'b00);
        req_valid = 2'b01;
        #1;
        expect_grant("add_grant", 2'b01);
        check("add_ctrl_grant_cycle", alu_control, 64'd0);
        step();
        req_valid = 2'b00;
        drive_port(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b11);
        #1;
        check("add_ctrl_w1",  alu_control, 64'd1);
        check("add_alu_A",    alu_A,       64'h3F800000);
        check("add_alu_B",    alu_B,       64'h40000000);
        check("add_nrsp_w1",  rsp_valid,   64'd0);
        step(); #1;
        check("add_ctrl_w2",  alu_control, 64'd1);
        check("add_nrsp_w2",  rsp_valid,   64'd0);
        step(); #1;
        check("add_latency",  rsp_valid,   64'd1);
        check("add_ctrl_off", alu_control, 64'd0);
        check("add_result",   rsp_out,     64'h40400000);
        check("add_exc",      rsp_exception, 64'd0);
        wait_rsp(0);
        check("add_idle_busy", busy,  64'd0);
        check("add_alu_hold",  alu_A, 64'h3F800000);

        // Divide by zero on port1.
        step();
        drive_port(1, 32'h3F800000, 32'h00000000, 2'b11);
        req_valid = 2'b10;
        #1;
        expect_grant("div0_grant", 2'b10);
        step();
        req_valid = 2'b00;
        #1;
        wait_rsp(0);

        // Response backpressure on port0 while port1 waits.
        step();
        drive_port(0, 32'h12345678, 32'h9ABCDEF0, 2'b01);
        req_valid = 2'b01;
        #1;
        expect_grant("bp_grant_p0", 2'b01);
        step();
        drive_port(1, 32'h0BADF00D, 32'h01234567, 2'b10);
        req_valid = 2'b10;
        #1;
        check("bp_no_grant_wait", req_ready, 64'd0);
        wait_rsp(5);
        expect_grant("bp_grant_p1", 2'b10);
        step();
        req_valid = 2'b00;
        #1;
        wait_rsp(0);

        // Reset during the second WAIT cycle discards the operation.
        step();
        drive_port(0, 32'hCAFEBABE, 32'h13572468, 2'b10);
        req_valid = 2'b01;
        #1;
        expect_grant("rst_grant", 2'b01);
        step();
        req_valid = 2'b00;
        #1;
        check("rst_wait1_ctrl", alu_control, 64'd1);
        step();
        reset = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        sb.delete();
        step();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(); #1;
            check("rst_no_rsp", rsp_valid, 64'd0);
        end
        step();
        drive_port(0, 32'h40400000, 32'h40800000, 2'b10);
        drive_port(1, 32'h41000000, 32'h40000000, 2'b11);
        req_valid = 2'b11;
        #1;
        expect_grant("rst_ptr_p0", 2'b01);
        step();
        req_valid = 2'b00;
        #1;
        wait_rsp(0);

`ifdef FPU_SCHED_STATS_EN
        step();
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        #1;
        check("st_pre_ops0", stat_ops0, 64'd0);
        check("st_pre_exc",  stat_exc,  64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            if (i == 1) drive_port(0, 32'h7F800000, 32'hFF800000, 2'b00);
            else        drive_port(0, 32'h00001000 + 32'(i), 32'h00020003, 2'b01);
            req_valid = 2'b01;
            #1;
            expect_grant("st_grant", 2'b01);
            step();
            req_valid = 2'b00;
            #1;
            wait_rsp(0);
        end
        check("st_ops0", stat_ops0, 64'd3);
        check("st_ops1", stat_ops1, 64'd0);
        check("st_exc",  stat_exc,  64'd1);
        check("st_zdiv", stat_zdiv, 64'd0);
        step();
        drive_port(0, 32'h00000777, 32'h00000111, 2'b00);
        req_valid = 2'b01;
        #1;
        expect_grant("st_grant4", 2'b01);
        step();
        req_valid = 2'b00;
        stat_clr  = 1'b1;
        #1;
        wait_rsp(0);
        stat_clr = 1'b0;
        check("st_clr_ops0", stat_ops0, 64'd0);
        check("st_clr_ops1", stat_ops1, 64'd0);
        check("st_clr_exc",  stat_exc,  64'd0);
        check("st_clr_zdiv", stat_zdiv, 64'd0);
`endif

        check("sb_drained", sb.size(), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fpu_op_scheduler.md
Name: fpu_op_scheduler

Overview:
- Arbitrates two independent requesters (port 0, port 1) onto one shared combinational IEEE-754 single-precision ALU (add/sub/mul/div).
- Registers the winning request's operands and opcode, holds them steady while the ALU settles for SETTLE cycles, captures the result and flags, and returns them to the owning requester over a valid/ready response channel.
- Sits between the two issuing engines and the ALU instance; one operation in flight at a time.

Parameters:
- SETTLE, 2, cycles ALU inputs are held stable before the result is captured; legal range 1..15.
- CNT_W, 16, width of the optional statistics counters.

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- reset  input  1  asynchronous, active-low reset; clears all state immediately; release is synchronous to clk
- req_valid  input  2  per-port request valid
- req_ready  output  2  per-port request accepted, one-hot or zero
- req_A  input  64  {port1, port0} operand A, 32 bits each
- req_B  input  64  {port1, port0} operand B, 32 bits each
- req_sel  input  4  {port1, port0} opcode, 2 bits each: 00 add, 01 sub, 10 mul, 11 div
- rsp_valid  output  2  per-port response valid, one-hot or zero
- rsp_ready  input  2  per-port response accept
- rsp_out  output  32  result, shared by both ports
- rsp_exception  output  1  captured ALU exception flag
- rsp_zeroDiv  output  1  captured divide-by-zero flag
- alu_A  output  32  ALU operand A
- alu_B  output  32  ALU operand B
- alu_select  output  2  ALU opcode
- alu_control  output  1  ALU enable, high only in the WAIT state
- alu_out  input  32  ALU result
- alu_exception  input  1  ALU exception flag
- alu_zeroDiv  input  1  ALU divide-by-zero flag
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_out=0, rsp_exception=0, rsp_zeroDiv=0, alu_A=0, alu_B=0, alu_select=0, alu_control=0, busy=0, FSM=IDLE, round-robin pointer=port 0.
- FSM states:
  - IDLE: if any req_valid is set, grant one port. req_ready pulses for exactly one cycle in the grant cycle, combinational from state, valid and pointer. In that same edge, latch the granted port's A, B and sel into alu_A, alu_B and alu_select, record the owner, and go to WAIT. Toggle the pointer to the other port only after a grant.
  - WAIT: alu_control=1. A counter loads SETTLE-1 on entry and decrements each cycle. When the counter reaches 0, capture alu_out, alu_exception and alu_zeroDiv into the rsp_* outputs, set rsp_valid[owner]=1, and go to RESP. Total WAIT time is exactly SETTLE cycles.
  - RESP: hold rsp_valid and data stable until rsp_ready[owner]=1. On that edge, clear rsp_valid and go to IDLE. rsp_ready of the non-owner port is ignored.
- Arbitration:
  - If only one port is valid, it wins.
  - If both are valid, the pointer port wins.
  - No new grant is made in WAIT or RESP; req_ready stays 0 there.
- Latency: grant edge to rsp_valid high is SETTLE+1 cycles. The minimum back-to-back issue interval is SETTLE+2 cycles with rsp_ready held high.
- Operands and opcode on alu_* change only on a grant edge. They hold their last value in IDLE; they are not zeroed.
- A requester changing req_* after its grant has no effect on the operation in flight.
- Reset asserted mid-operation: everything returns to reset values at once, and the in-flight operation is discarded with no response.
- Flags pass through unmodified. The scheduler does not interpret NaN or Inf, and zeroDiv is captured for every opcode exactly as the ALU drives it.

Optional Feature:
- Macro: FPU_SCHED_STATS_EN.
- When defined, add the following outputs:
  - stat_ops0 [CNT_W]: count of completed response handshakes for port 0.
  - stat_ops1 [CNT_W]: count of completed response handshakes for port 1.
  - stat_exc [CNT_W]: count of captured exception=1 results.
  - stat_zdiv [CNT_W]: count of captured zeroDiv=1 results.
  - stat_clr (input, 1): synchronous clear.
- Counter rules:
  - All counters saturate at all-ones and reset to 0.
  - stat_clr has priority over an increment in the same cycle.
- When the macro is not defined, these ports and their logic do not exist, and the remaining behaviour is identical.

Test Plan:
- Single add, SETTLE=2: port0 A=0x3F800000, B=0x40000000, sel=00 → req_ready[0] pulses 1 cycle; alu_control high 2 cycles; rsp_valid[0] 3 cycles after grant; rsp_out=0x40400000, exception=0.
- Contention: both ports valid in the same cycle after reset → port0 granted first; port1 granted in the first IDLE cycle after port0's response handshake; pointer then favours port0 again.
- Divide by zero: port1 A=0x3F800000, B=0x00000000, sel=11 → rsp_valid[1]=1, rsp_zeroDiv equals the ALU's zeroDiv (1); rsp_valid[0] stays 0.
- Response backpressure: hold rsp_ready[0]=0 for 5 cycles with port1 valid → rsp_out stable, req_ready[1] stays 0, busy=1; port1 is granted the cycle after the handshake.
- Reset mid-WAIT: drive reset low during the second WAIT cycle → all outputs go to reset values immediately; no rsp_valid after release; next request is served normally.
- FPU_SCHED_STATS_EN: 3 port0 ops, one with exception=1, then stat_clr coincident with a 4th completion → counts 3/0/1/0 before the clear, and all 0 after it.
